seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits; SHALL be a power of two, range 4..64.
REQ-002 Derived constant: AW = $clog2(WIDTH), the shift-amount width and the number of shift stages.
REQ-003 Port: clk  in  1  single clock; all state SHALL update on rising edge.
REQ-004 Port: nrst  in  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  in  1  request present.
REQ-006 Port: in_ready  out  1  block can accept a request.
REQ-007 Port: in_data  in  WIDTH  operand, signed for ASR.
REQ-008 Port: in_amt  in  AW  shift amount, 0..WIDTH-1.
REQ-009 Port: in_mode  in  3  operation: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101..111 pass-through.
REQ-010 Port: out_valid  out  1  result present.
REQ-011 Port: out_ready  in  1  consumer accepts result.
REQ-012 Port: out_data  out  WIDTH  result.
REQ-013 Port: out_sticky  out  1  OR of all bits shifted out.

Function
REQ-014 States SHALL be IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 IDLE: on in_valid & in_ready, latch in_data, in_amt, in_mode, clear stage counter and sticky, go to SHIFT.
REQ-016 SHIFT: one stage per cycle, stage k (k = 0..AW-1) shifts/rotates by 2^k when latched amt bit k = 1, else holds.
REQ-017 SHIFT SHALL last exactly AW cycles regardless of amount, including amount 0; after stage AW-1, go to DONE.
REQ-018 Latency: out_valid SHALL rise AW cycles after the accepting edge (WIDTH=8: 3 cycles).
REQ-019 LSL/LSR SHALL fill vacated bits with 0; ASR SHALL fill with latched bit WIDTH-1.
REQ-020 ROL/ROR SHALL lose no bits; out_sticky SHALL be 0.
REQ-021 Pass-through modes SHALL return the latched operand unchanged with out_sticky 0, same latency.
REQ-022 DONE: out_data/out_sticky SHALL stay stable while out_valid & !out_ready; in_valid ignored.
REQ-023 DONE: on out_ready, go to IDLE; next request is acceptable on the following edge (no same-cycle accept).
REQ-024 Input ports SHALL be ignored outside IDLE; changes during SHIFT SHALL not affect the result.
REQ-025 out_data and out_sticky SHALL be registered, no combinational path from inputs.

Reset
REQ-026 nrst = 0 at a rising edge SHALL force IDLE, out_data = 0, out_sticky = 0, stage counter = 0, in_ready = 1, out_valid = 0 after that edge.
REQ-027 Reset during SHIFT or DONE SHALL abandon the operation; no result is ever emitted for it.
REQ-028 Reset SHALL dominate a simultaneous in_valid or out_ready.

Configuration
REQ-029 Macro SEQ_SHIFTER_STICKY_EN defined: out_sticky SHALL accumulate, per stage, the OR of bits discarded by LSL/LSR/ASR.
REQ-030 Macro SEQ_SHIFTER_STICKY_EN undefined: out_sticky port SHALL exist and be constant 0; no sticky logic.

Verification (WIDTH=8, SEQ_SHIFTER_STICKY_EN defined unless stated)
REQ-031 LSL 8'hB5 amt 3 -> out_valid 3 cycles after accept, out_data 8'hA8, out_sticky 1 (0 with macro undefined).
REQ-032 ASR 8'h90 amt 2 -> out_data 8'hE4, out_sticky 0; ROR 8'h01 amt 1 -> 8'h80, sticky 0.
REQ-033 ROL 8'h81 amt 7 -> 8'hC0, sticky 0; LSR 8'hFF amt 0 -> 8'hFF, sticky 0, still 3-cycle latency.
REQ-034 Hold out_ready = 0 for 5 cycles in DONE while toggling in_valid/in_data -> out_data stable, in_ready 0, single result on release.
REQ-035 Assert nrst = 0 in the 2nd SHIFT cycle -> next cycle in_ready 1, out_valid 0, out_data 0; following request completes normally.
REQ-036 Mode 3'b110 with 8'h5A amt 4 -> out_data 8'h5A, out_sticky 0.

Source files
------------

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : seq_shifter
// Brief    : Multi-cycle barrel shifter (LSL/LSR/ASR/ROL/ROR/pass) that
//            resolves one power-of-two stage per clock with valid/ready I/O.
//            Define SEQ_SHIFTER_STICKY_EN to enable the shifted-out sticky bit.
// Revision : 1.0 - initial release
// ============================================================================

module seq_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_amt,
    input  logic [2:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_sticky
);

    localparam int AW = $clog2(WIDTH);

    localparam logic [2:0]       c_mode_lsl   = 3'b000;
    localparam logic [2:0]       c_mode_lsr   = 3'b001;
    localparam logic [2:0]       c_mode_asr   = 3'b010;
    localparam logic [2:0]       c_mode_rol   = 3'b011;
    localparam logic [2:0]       c_mode_ror   = 3'b100;
    localparam logic [AW-1:0]    c_last_stage = AW'(AW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_data;
    logic [AW-1:0]     r_amt;
    logic [2:0]        r_mode;
    logic [AW-1:0]     r_stage;

    logic [AW-1:0]     w_step;
    logic [AW-1:0]     w_rinv;
    logic [WIDTH-1:0]  w_shl;
    logic [WIDTH-1:0]  w_shr;
    logic [WIDTH-1:0]  w_asr;
    logic [WIDTH-1:0]  w_rol;
    logic [WIDTH-1:0]  w_ror;
    logic [WIDTH-1:0]  w_stage_data;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_stage == c_last_stage) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One shift stage: distance 2^stage. The remaining amount is shifted
    // right each stage so bit 0 always selects the current stage.
    // ------------------------------------------------------------------
    always_comb begin
        w_step = AW'(1) << r_stage;
        w_rinv = AW'(0) - w_step;
        w_shl  = r_data << w_step;
        w_shr  = r_data >> w_step;
        w_asr  = $signed(r_data) >>> w_step;
        w_rol  = w_shl | (r_data >> w_rinv);
        w_ror  = w_shr | (r_data << w_rinv);

        w_stage_data = r_data;
        if (r_amt[0]) begin
            case (r_mode)
                c_mode_lsl: w_stage_data = w_shl;
                c_mode_lsr: w_stage_data = w_shr;
                c_mode_asr: w_stage_data = w_asr;
                c_mode_rol: w_stage_data = w_rol;
                c_mode_ror: w_stage_data = w_ror;
                default:    w_stage_data = r_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_data  <= '0;
            r_amt   <= '0;
            r_mode  <= '0;
            r_stage <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_amt   <= in_amt;
                        r_mode  <= in_mode;
                        r_stage <= '0;
                    end
                end
                SHIFT: begin
                    r_data <= w_stage_data;
                    r_amt  <= r_amt >> 1;
                    if (r_stage == c_last_stage) begin
                        r_stage <= '0;
                    end else begin
                        r_stage <= r_stage + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = r_data;

`ifdef SEQ_SHIFTER_STICKY_EN
    localparam logic [WIDTH-1:0] c_ones = '1;

    logic              r_sticky;
    logic [WIDTH-1:0]  w_lost_hi;
    logic [WIDTH-1:0]  w_lost_lo;
    logic              w_stage_lost;

    // Bits that fall off the top (left shifts) or bottom (right shifts)
    always_comb begin
        w_lost_hi    = r_data & ~(c_ones >> w_step);
        w_lost_lo    = r_data & ~(c_ones << w_step);
        w_stage_lost = 1'b0;
        if (r_amt[0]) begin
            case (r_mode)
                c_mode_lsl: w_stage_lost = |w_lost_hi;
                c_mode_lsr: w_stage_lost = |w_lost_lo;
                c_mode_asr: w_stage_lost = |w_lost_lo;
                default:    w_stage_lost = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sticky <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sticky <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_sticky <= r_sticky | w_stage_lost;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_sticky = r_sticky;
`else
    assign out_sticky = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_shifter
// Brief    : Self-checking bench for seq_shifter (WIDTH=8): directed cases
//            plus randomized operations against a wide-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_seq_shifter;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          nrst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic [2:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_sticky;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SEQ_SHIFTER_STICKY_EN
    localparam bit c_sticky_en = 1'b1;
`else
    localparam bit c_sticky_en = 1'b0;
`endif

    seq_shifter #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-operand reference: shifts done in a double-width window
    function automatic void model(input logic [W-1:0] d, input logic [AW-1:0] a,
                                  input logic [2:0] m,
                                  output logic [W-1:0] r, output logic s);
        logic [2*W-1:0] wide;
        int             ai;
        ai = int'(a);
        r  = d;
        s  = 1'b0;
        case (m)
            3'd0: begin
                wide = {{W{1'b0}}, d} << ai;
                r    = wide[W-1:0];
                s    = |wide[2*W-1:W];
            end
            3'd1: begin
                wide = {d, {W{1'b0}}} >> ai;
                r    = wide[2*W-1:W];
                s    = |wide[W-1:0];
            end
            3'd2: begin
                wide = {{W{d[W-1]}}, d} >> ai;
                r    = wide[W-1:0];
                wide = {d, {W{1'b0}}} >> ai;
                s    = |wide[W-1:0];
            end
            3'd3: begin
                wide = {d, d} << ai;
                r    = wide[2*W-1:W];
            end
            3'd4: begin
                wide = {d, d} >> ai;
                r    = wide[W-1:0];
            end
            default: begin
                r = d;
            end
        endcase
        if (!c_sticky_en) s = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, hold the result for 'hold' cycles, then release it
    task automatic run_op(input string tag, input logic [W-1:0] d, input logic [AW-1:0] a,
                          input logic [2:0] m, input int hold,
                          input logic [W-1:0] exp_d, input logic exp_s);
        int           waitc;
        int           lat;
        logic [W-1:0] held_d;
        logic         held_s;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        check({tag, "/ready"}, in_ready, 1);
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        in_valid = 1'b1;
        tick();
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            in_amt   = AW'($urandom);
            in_mode  = 3'($urandom);
            tick();
            lat++;
        end
        check({tag, "/latency"}, lat, AW);
        check({tag, "/data"}, out_data, exp_d);
        check({tag, "/sticky"}, out_sticky, exp_s);
        held_d = out_data;
        held_s = out_sticky;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            tick();
            check({tag, "/hold_valid"}, out_valid, 1);
            check({tag, "/hold_ready"}, in_ready, 0);
            check({tag, "/hold_data"}, {out_sticky, out_data}, {held_s, held_d});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/release_valid"}, out_valid, 0);
        check({tag, "/release_ready"}, in_ready, 1);
        if (hold > 0) begin
            tick();
            check({tag, "/single_result"}, out_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0]  rd;
        logic [AW-1:0] ra;
        logic [2:0]    rm;
        logic [W-1:0]  ed;
        logic          es;
        int            lat;

        nrst      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset/in_ready", in_ready, 1);
        check("reset/out_valid", out_valid, 0);
        check("reset/out_data", out_data, 0);
        check("reset/out_sticky", out_sticky, 0);
        nrst = 1'b1;
        tick();

        run_op("lsl_b5_3",  8'hB5, 3'd3, 3'b000, 0, 8'hA8, c_sticky_en);
        run_op("asr_90_2",  8'h90, 3'd2, 3'b010, 0, 8'hE4, 1'b0);
        run_op("ror_01_1",  8'h01, 3'd1, 3'b100, 0, 8'h80, 1'b0);
        run_op("rol_81_7",  8'h81, 3'd7, 3'b011, 0, 8'hC0, 1'b0);
        run_op("lsr_ff_0",  8'hFF, 3'd0, 3'b001, 0, 8'hFF, 1'b0);
        run_op("pass_5a_4", 8'h5A, 3'd4, 3'b110, 0, 8'h5A, 1'b0);
        run_op("lsr_ff_7",  8'hFF, 3'd7, 3'b001, 0, 8'h01, c_sticky_en);
        run_op("asr_7f_7",  8'h7F, 3'd7, 3'b010, 0, 8'h00, c_sticky_en);
        run_op("hold_lsl",  8'h3C, 3'd2, 3'b000, 5, 8'hF0, 1'b0);

        // Reset in the second SHIFT cycle abandons the operation
        in_data  = 8'hC3;
        in_amt   = 3'd5;
        in_mode  = 3'b000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("rst_shift/in_ready", in_ready, 1);
        check("rst_shift/out_valid", out_valid, 0);
        check("rst_shift/out_data", out_data, 0);
        check("rst_shift/out_sticky", out_sticky, 0);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) lat++;
        end
        check("rst_shift/no_result", lat, 0);
        run_op("after_rst", 8'h96, 3'd1, 3'b001, 1, 8'h4B, 1'b0);

        // Reset beats a simultaneous request
        nrst     = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        nrst     = 1'b1;
        in_valid = 1'b0;
        check("rst_dom/in_ready", in_ready, 1);
        tick();
        check("rst_dom/not_accepted", in_ready, 1);

        // Reset while a result waits in DONE
        in_data  = 8'h11;
        in_amt   = 3'd1;
        in_mode  = 3'b011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (AW) tick();
        check("rst_done/pre_valid", out_valid, 1);
        nrst      = 1'b0;
        out_ready = 1'b1;
        tick();
        nrst      = 1'b0;
        out_ready = 1'b0;
        nrst      = 1'b1;
        check("rst_done/out_valid", out_valid, 0);
        check("rst_done/out_data", out_data, 0);

        for (int n = 0; n < 40; n++) begin
            rd = W'($urandom);
            ra = AW'($urandom);
            rm = 3'($urandom_range(0, 7));
            model(rd, ra, rm, ed, es);
            run_op($sformatf("rand%0d_m%0d_a%0d", n, rm, ra), rd, ra, rm,
                   int'($urandom_range(0, 2)), ed, es);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
